// File: rtl/fifo_uart_tx.sv
// FIFO-draining UART transmitter: pops one byte whenever the FIFO is non-empty and enabled,
// then sends start bit, 8 data bits LSB first, optional even parity, and one stop bit.
module fifo_uart_tx #(
    parameter int CLKS_PER_BIT = 434,
    parameter bit PARITY_EN    = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       fifo_empty,
    input  logic [7:0] fifo_data,
    output logic       fifo_read,
    output logic       tx,
    output logic       busy,
    output logic [7:0] frame_count
);

    localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t            state_q, state_d;
    logic [BAUD_W-1:0] baud_q, baud_d;
    logic [2:0]        bit_idx_q, bit_idx_d;
    logic [7:0]        shreg_q, shreg_d;
    logic              parity_q, parity_d;
    logic [7:0]        frame_count_q, frame_count_d;
    logic              baud_done;

    assign baud_done = (baud_q == BAUD_LAST);

    always_comb begin
        state_d       = state_q;
        baud_d        = baud_q + 1'b1;
        bit_idx_d     = bit_idx_q;
        shreg_d       = shreg_q;
        parity_d      = parity_q;
        frame_count_d = frame_count_q;

        case (state_q)
            IDLE: begin
                baud_d = '0;
                if (enable && !fifo_empty) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                baud_d    = '0;
                shreg_d   = fifo_data;
                parity_d  = ^fifo_data;
                bit_idx_d = '0;
                state_d   = START;
            end
            START: begin
                if (baud_done) begin
                    baud_d  = '0;
                    state_d = DATA;
                end
            end
            DATA: begin
                // The baud counter restarts for every bit, not only on state changes.
                if (baud_done) begin
                    baud_d    = '0;
                    shreg_d   = {1'b0, shreg_q[7:1]};
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) begin
                        state_d = PARITY_EN ? PARITY : STOP;
                    end
                end
            end
            PARITY: begin
                if (baud_done) begin
                    baud_d  = '0;
                    state_d = STOP;
                end
            end
            STOP: begin
                if (baud_done) begin
                    baud_d        = '0;
                    frame_count_d = frame_count_q + 8'd1;
                    state_d       = IDLE;
                end
            end
            default: begin
                baud_d  = '0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q       <= IDLE;
            baud_q        <= '0;
            bit_idx_q     <= '0;
            shreg_q       <= '0;
            parity_q      <= 1'b0;
            frame_count_q <= '0;
        end else begin
            state_q       <= state_d;
            baud_q        <= baud_d;
            bit_idx_q     <= bit_idx_d;
            shreg_q       <= shreg_d;
            parity_q      <= parity_d;
            frame_count_q <= frame_count_d;
        end
    end

    // Outputs depend only on registered state, never directly on inputs.
    always_comb begin
        tx = 1'b1;
        case (state_q)
            START:   tx = 1'b0;
            DATA:    tx = shreg_q[0];
            PARITY:  tx = parity_q;
            default: tx = 1'b1;
        endcase
    end

    assign fifo_read   = (state_q == LOAD);
    assign busy        = (state_q != IDLE);
    assign frame_count = frame_count_q;

endmodule

// File: doc/fifo_uart_tx.md
# fifo_uart_tx

FIFO-draining serial transmitter: the consumer on the read side of the board's 8-bit FIFO. Whenever the FIFO is non-empty and the block is enabled, it pops one byte and shifts it out on a single UART-style line: start bit, 8 data bits LSB first, optional even parity, one stop bit. It sits next to the FIFO in the top level. Its read strobe replaces the push-button read path, so entries written from the switches are streamed out automatically.

## Interface
Parameters:
- CLKS_PER_BIT, 434, clock cycles per serial bit (434 = 50 MHz / 115200); legal range >= 2
- PARITY_EN, 0, 0 = no parity bit; 1 = even parity bit inserted after data bit 7

Ports:
- clk  input  1  system clock (CLOCK_50 domain)
- reset  input  1  synchronous, active-low reset; one clock; sampled on rising edge of clk
- enable  input  1  1 = allowed to start new frames; does not abort a frame in progress
- fifo_empty  input  1  FIFO empty flag
- fifo_data  input  8  FIFO head entry (show-ahead); valid whenever fifo_empty = 0
- fifo_read  output  1  one-cycle pop strobe to the FIFO
- tx  output  1  serial line; idles high
- busy  output  1  1 whenever state != IDLE
- frame_count  output  8  count of completed frames; wraps 255 -> 0

## Operation
- Registered Moore FSM with states IDLE, LOAD, START, DATA, PARITY, STOP. The tx, fifo_read and busy outputs are all registered or decoded from the state only, with no input-to-output combinational path.
- IDLE: tx = 1. If enable = 1 and fifo_empty = 0 at a clock edge, go to LOAD.
- LOAD: lasts exactly one cycle with fifo_read = 1. At the edge ending LOAD:
  - fifo_data is captured into an 8-bit shift register;
  - the parity bit (XOR of the 8 bits) is captured;
  - the FSM goes to START.
- START: tx = 0 for CLKS_PER_BIT cycles, then go to DATA.
- DATA: tx = shreg[0] for CLKS_PER_BIT cycles per bit. Shift right after each bit. After 8 bits (3-bit index 0..7), go to PARITY if PARITY_EN = 1, else STOP.
- PARITY: tx = captured even-parity bit for CLKS_PER_BIT cycles, then go to STOP.
- STOP: tx = 1 for CLKS_PER_BIT cycles. At the final edge, increment frame_count modulo 256 and go to IDLE.
- Baud counter: width $clog2(CLKS_PER_BIT), counts 0..CLKS_PER_BIT-1, cleared on every state change.
- enable dropped mid-frame: the current frame completes normally; no new LOAD occurs until enable = 1 again.
- fifo_empty going high mid-frame: ignored. It is only sampled in IDLE.
- fifo_read is never asserted outside LOAD, so the block cannot pop an empty FIFO.

## Timing
- Reset (reset = 0 at an edge) drives, from the next cycle: state = IDLE, tx = 1, fifo_read = 0, busy = 0, frame_count = 0, shift register = 0, baud counter = 0, bit index = 0.
- Reset takes priority over all other inputs in every state.
- Reset during START, DATA or PARITY aborts the frame: tx = 1 from the next cycle. The byte already popped is lost, and the FIFO is not re-read.
- Latency: if fifo_empty = 0 and enable = 1 are sampled in IDLE at edge N:
  - fifo_read is high for cycle N..N+1;
  - tx falls at edge N+1;
  - busy rises at edge N.
- Frame length with tx != idle: (10 + PARITY_EN) × CLKS_PER_BIT cycles from the start-bit edge to the end of the stop bit.
- Back-to-back frames: 2-cycle gap (one IDLE cycle plus the LOAD cycle) with tx = 1. This gives a start-edge-to-start-edge period of (10 + PARITY_EN) × CLKS_PER_BIT + 2 cycles.
- frame_count updates on the same edge at which STOP exits to IDLE.

## Test plan
All scenarios use CLKS_PER_BIT = 4 and a behavioral show-ahead FIFO model unless stated otherwise.

- **Reset:** hold reset = 0 for 2 edges with fifo_empty = 0 and enable = 1 -> tx = 1, fifo_read = 0, busy = 0, frame_count = 0 throughout; no pop occurs.
- **Single byte:** PARITY_EN = 0, FIFO holds 0xA5 -> exactly one fifo_read pulse, one cycle wide. tx then carries 0,1,0,1,0,0,1,0,1,1 with each bit held 4 cycles (40 cycles total), and frame_count = 1 afterwards.
- **Back-to-back:** FIFO holds 0x01, 0x02, 0x03 -> exactly 3 fifo_read pulses and start edges 42 cycles apart. After the third stop bit: fifo_empty = 1, busy = 0, frame_count = 3, tx = 1.
- **Parity:** PARITY_EN = 1, bytes 0x07 then 0x03 -> parity bits 1 then 0, frame length 44 cycles each.
- **Gating:** fifo_empty = 1 for 100 cycles -> no fifo_read and tx = 1. Then enable = 0 with the FIFO non-empty -> no pop. Finally, drop enable mid-DATA -> the frame completes and no further pop occurs.
- **Reset mid-frame:** assert reset during the DATA bit 3 of 0xFF -> tx = 1 and busy = 0 one cycle later, frame_count = 0. After release with the FIFO non-empty, the next byte transmits correctly.
